// File: rtl/arr_pkg.sv
// Shared state encoding and default array geometry for the systolic-array
// operand sequencer.
package arr_pkg;
  localparam int DEF_ROWS    = 8;
  localparam int DEF_COLS    = 8;
  localparam int DEF_INWIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/arr_seq_if.sv
// Operand/array/status bundle between the sequencer (slave) and whatever
// drives jobs and supplies operands (master).
interface arr_seq_if import arr_pkg::*; #(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int INWIDTH = DEF_INWIDTH,
  parameter int KW      = 16
);
  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     op_valid;
  logic [COLS*INWIDTH-1:0]  w_vec;
  logic [ROWS*INWIDTH-1:0]  a_vec;
  logic                     op_rd;
  logic [COLS*INWIDTH-1:0]  arr_w;
  logic [ROWS*INWIDTH-1:0]  arr_a;
  logic                     arr_fire;
  logic                     arr_clr;
  logic                     last_valid;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, k_len, op_valid, w_vec, a_vec, last_valid,
    input  op_rd, arr_w, arr_a, arr_fire, arr_clr, busy, done, err
  );

  modport slave (
    input  start, k_len, op_valid, w_vec, a_vec, last_valid,
    output op_rd, arr_w, arr_a, arr_fire, arr_clr, busy, done, err
  );
endinterface

// File: rtl/skew_line.sv
// Per-lane delay line: DEPTH+1 registers, so DEPTH=0 is a single register.
module skew_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= DEPTH; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int k = 1; k <= DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DEPTH];
endmodule

// File: rtl/arr_seq.sv
// Job sequencer for a ROWSxCOLS systolic array: clears accumulators, streams
// k_len operand beats through diagonal skew lines, flushes, then waits for the
// bottom-right PE result with a timeout.
module arr_seq import arr_pkg::*; #(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int INWIDTH = DEF_INWIDTH,
  parameter int KW      = 16,
  parameter int TMO     = 64
) (
  input  logic     clk,
  input  logic     rst,
  arr_seq_if.slave bus
);
  localparam int TW         = $clog2(TMO + ROWS + COLS + 1);
  localparam int FLUSH_LAST = (ROWS + COLS > 2) ? ROWS + COLS - 3 : 0;

  state_t                  r_state, w_next;
  logic [KW-1:0]           r_klen, r_cnt;
  logic [KW-1:0]           w_cnt_nxt;
  logic [TW-1:0]           r_tmr;
  logic                    r_err, r_fire;
  logic                    w_op_rd, w_accept, w_clr, w_busy, w_done, w_tmo;
  logic [COLS*INWIDTH-1:0] w_w_in, w_w_skew;
  logic [ROWS*INWIDTH-1:0] w_a_in, w_a_skew;

  assign w_accept  = w_op_rd && bus.op_valid;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_tmo     = (r_tmr == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_op_rd = 1'b0;
    w_clr   = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = CLEAR;
      end
      CLEAR: begin
        w_clr  = 1'b1;
        w_next = (r_klen == '0) ? DONE : LOAD;
      end
      LOAD: begin
        // r_cnt never passes r_klen, so a full-range k_len cannot wrap
        w_op_rd = (r_cnt != r_klen);
        if (w_op_rd && bus.op_valid && (w_cnt_nxt == r_klen)) w_next = FLUSH;
      end
      FLUSH: if (r_tmr == TW'(FLUSH_LAST)) w_next = DRAIN;
      DRAIN: if (bus.last_valid || w_tmo) w_next = DONE;
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen <= '0;
      r_cnt  <= '0;
      r_tmr  <= '0;
      r_err  <= 1'b0;
      r_fire <= 1'b0;
    end else begin
      r_fire <= w_accept && (r_cnt == '0);
      if (r_state == IDLE && bus.start) begin
        r_klen <= bus.k_len;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_nxt;
      end
      if (w_next != r_state) r_tmr <= '0;
      else if (r_state == FLUSH || r_state == DRAIN) r_tmr <= r_tmr + 1'b1;
      if (r_state == DRAIN && !bus.last_valid && w_tmo) r_err <= 1'b1;
    end
  end

  // Non-accepted cycles feed zeros on every lane at once, keeping w/a aligned
  assign w_w_in = w_accept ? bus.w_vec : '0;
  assign w_a_in = w_accept ? bus.a_vec : '0;

  for (genvar j = 0; j < COLS; j++) begin : g_col
    skew_line #(.DEPTH(j), .WIDTH(INWIDTH)) u_skew (
      .clk (clk),
      .rst (rst),
      .i_d (w_w_in[j*INWIDTH +: INWIDTH]),
      .o_q (w_w_skew[j*INWIDTH +: INWIDTH])
    );
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    skew_line #(.DEPTH(i), .WIDTH(INWIDTH)) u_skew (
      .clk (clk),
      .rst (rst),
      .i_d (w_a_in[i*INWIDTH +: INWIDTH]),
      .o_q (w_a_skew[i*INWIDTH +: INWIDTH])
    );
  end

  assign bus.op_rd    = w_op_rd;
  assign bus.arr_clr  = w_clr;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.err      = r_err;
  assign bus.arr_fire = r_fire;
  assign bus.arr_w    = (r_state == IDLE) ? '0 : w_w_skew;
  assign bus.arr_a    = (r_state == IDLE) ? '0 : w_a_skew;
endmodule

// File: tb/tb_arr_seq.sv
// Randomized scoreboard bench for arr_seq: the driver predicts lane arrival
// cycles and control pulses from the job rules; a monitor checks every cycle.
module tb_arr_seq;
  import arr_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int INW   = 8;
  localparam int KW    = 4;
  localparam int TMO   = 64;
  localparam int FLUSH = ROWS + COLS - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arr_seq_if #(.ROWS(ROWS), .COLS(COLS), .INWIDTH(INW), .KW(KW)) bus ();

  arr_seq #(.ROWS(ROWS), .COLS(COLS), .INWIDTH(INW), .KW(KW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; int lane; bit isw; logic [INW-1:0] d; } lane_t;
  typedef struct { int cyc; bit err; } done_t;

  lane_t lq[$];
  int    clrq[$];
  int    fireq[$];
  done_t doneq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rvec();
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = 8'($urandom_range(1, 255));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_busy"},  bus.busy,     1'b0);
    chk1({tag, "_done"},  bus.done,     1'b0);
    chk1({tag, "_err"},   bus.err,      1'b0);
    chk1({tag, "_op_rd"}, bus.op_rd,    1'b0);
    chk1({tag, "_fire"},  bus.arr_fire, 1'b0);
    chk1({tag, "_clr"},   bus.arr_clr,  1'b0);
    chkv({tag, "_arr_w"}, bus.arr_w,    64'd0);
    chkv({tag, "_arr_a"}, bus.arr_a,    64'd0);
  endtask

  // Monitor: every cycle, the skewed lanes must carry exactly the beats due now
  always @(negedge clk) begin : mon
    logic [63:0] ew, ea;
    if (mon_en) begin
      ew = '0;
      ea = '0;
      for (int k = lq.size() - 1; k >= 0; k--) begin
        if (lq[k].cyc <= cyc) begin
          if (lq[k].cyc == cyc) begin
            if (lq[k].isw) ew[lq[k].lane*INW +: INW] = lq[k].d;
            else           ea[lq[k].lane*INW +: INW] = lq[k].d;
          end
          lq.delete(k);
        end
      end
      chkv("arr_w", bus.arr_w, ew);
      chkv("arr_a", bus.arr_a, ea);

      if (clrq.size() > 0 && clrq[0] == cyc) begin
        chk1("arr_clr_pulse", bus.arr_clr, 1'b1);
        clrq.delete(0);
      end else chk1("arr_clr_quiet", bus.arr_clr, 1'b0);

      if (fireq.size() > 0 && fireq[0] == cyc) begin
        chk1("arr_fire_pulse", bus.arr_fire, 1'b1);
        fireq.delete(0);
      end else chk1("arr_fire_quiet", bus.arr_fire, 1'b0);

      if (doneq.size() > 0 && doneq[0].cyc == cyc) begin
        chk1("done_pulse", bus.done, 1'b1);
        chk1("err_at_done", bus.err, doneq[0].err);
        doneq.delete(0);
      end else chk1("done_quiet", bus.done, 1'b0);
    end
  end

  // vmode: 0 = op_valid always 1, 1 = 1,0,1,0.. from first LOAD cycle, 2 = random
  // lvd: DRAIN cycle index where last_valid rises, <0 or >=TMO means never
  // rst_after: assert rst after that many acceptances (<0 = never)
  task automatic run_job(input int k, input int vmode, input int lvd,
                         input bit poke, input int rst_after);
    int s, n, acc, budget, p, dstart, lvc, dcyc;
    bit v, exp_err, aborted;
    lane_t e;
    done_t d;
    tick();
    s = cyc;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    clrq.push_back(s + 1);
    if (k == 0) begin
      d.cyc = s + 2;
      d.err = 1'b0;
      doneq.push_back(d);
    end
    tick();
    bus.start    = 1'b0;
    bus.k_len    = KW'($urandom);
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk1("busy_in_clear", bus.busy, 1'b1);
    chk1("err_cleared_by_start", bus.err, 1'b0);
    chk1("no_op_rd_in_clear", bus.op_rd, 1'b0);

    n = s + 1;
    acc = 0;
    budget = 0;
    aborted = 1'b0;
    while (acc < k && budget < 200) begin
      tick();
      p = cyc - (s + 2);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (p % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.op_valid = v;
      bus.w_vec    = rvec();
      bus.a_vec    = rvec();
      bus.k_len    = KW'($urandom);
      @(negedge clk);
      if (bus.op_valid && bus.op_rd) begin
        n = cyc;
        if (acc == 0) fireq.push_back(n + 1);
        for (int j = 0; j < COLS; j++) begin
          e.cyc = n + 1 + j; e.lane = j; e.isw = 1'b1; e.d = bus.w_vec[j*INW +: INW];
          lq.push_back(e);
        end
        for (int i = 0; i < ROWS; i++) begin
          e.cyc = n + 1 + i; e.lane = i; e.isw = 1'b0; e.d = bus.a_vec[i*INW +: INW];
          lq.push_back(e);
        end
        acc++;
        if (rst_after >= 0 && acc == rst_after) begin
          aborted = 1'b1;
          break;
        end
      end
      budget++;
    end

    if (aborted) begin
      tick();
      rst = 1'b1;
      bus.op_valid = 1'b0;
      tick();
      rst = 1'b0;
      lq.delete();
      fireq.delete();
      clrq.delete();
      doneq.delete();
      @(negedge clk);
      chk_quiet("after_rst");
      return;
    end

    if (k == 0) begin
      dcyc = s + 2;
      exp_err = 1'b0;
      lvc = -1;
    end else begin
      chki("beats_accepted", acc, k);
      tick();
      bus.op_valid = 1'b1;
      bus.w_vec    = rvec();
      bus.a_vec    = rvec();
      @(negedge clk);
      chk1("op_rd_after_last", bus.op_rd, 1'b0);
      dstart = n + 1 + FLUSH;
      if (lvd >= 0 && lvd < TMO) begin
        lvc = dstart + lvd;
        dcyc = lvc + 1;
        exp_err = 1'b0;
      end else begin
        lvc = -1;
        dcyc = dstart + TMO;
        exp_err = 1'b1;
      end
      d.cyc = dcyc;
      d.err = exp_err;
      doneq.push_back(d);
    end

    while (cyc < dcyc + 1) begin
      tick();
      bus.op_valid   = ($urandom_range(0, 1) == 1);
      bus.w_vec      = rvec();
      bus.a_vec      = rvec();
      bus.k_len      = KW'($urandom);
      bus.last_valid = (cyc == lvc);
      bus.start      = poke && (k > 0) && (cyc == dstart + 2);
    end
    bus.start = 1'b0;
    bus.last_valid = 1'b0;
    @(negedge clk);
    chk1("idle_after_done", bus.busy, 1'b0);
    chk1("err_sticky", bus.err, exp_err);
    tick();
    @(negedge clk);
    chk1("stays_idle", bus.busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kr, lr;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.op_valid = 1'b0;
    bus.w_vec = '0;
    bus.a_vec = '0;
    bus.last_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    run_job(4, 0, 2, 1'b0, -1);
    run_job(3, 1, 0, 1'b0, -1);
    run_job(0, 0, 0, 1'b0, -1);
    run_job(2, 0, -1, 1'b0, -1);
    run_job(6, 2, 3, 1'b0, -1);
    run_job(8, 2, 1, 1'b0, 3);
    run_job(8, 0, 5, 1'b0, -1);
    run_job(5, 2, 10, 1'b1, -1);
    run_job(15, 2, 0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      kr = $urandom_range(0, 15);
      lr = $urandom_range(0, 8);
      run_job(kr, 2, lr, (lr > 3) && ($urandom_range(0, 1) == 1), -1);
    end

    repeat (2) tick();
    chki("pending_expectations", lq.size() + clrq.size() + fireq.size() + doneq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arr_seq.md
ARR_SEQ -- requirements
Module: arr_seq

Interface
REQ-001 Parameters SHALL be: ROWS, default 8, array rows; COLS, default 8, array columns; INWIDTH, default 8, operand width; KW, default 16, inner-dimension length counter width; TMO, default 64, drain-timeout cycles.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  job request, sampled in IDLE only.
REQ-005 k_len  in  KW  inner-dimension beat count, captured with start.
REQ-006 op_valid  in  1  operand source holds one beat (w_vec and a_vec).
REQ-007 w_vec  in  COLS*INWIDTH  weight beat, lane j feeds column j.
REQ-008 a_vec  in  ROWS*INWIDTH  activation beat, lane i feeds row i.
REQ-009 op_rd  out  1  pop strobe; a beat is accepted when op_valid and op_rd are both high.
REQ-010 arr_w  out  COLS*INWIDTH  skewed weights to array top edge.
REQ-011 arr_a  out  ROWS*INWIDTH  skewed activations to array left edge.
REQ-012 arr_fire  out  1  fire pulse into array origin PE.
REQ-013 arr_clr  out  1  accumulator clear pulse to all PEs.
REQ-014 last_valid  in  1  result-valid of the bottom-right PE.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  sticky drain-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, LOAD, FLUSH, DRAIN, DONE.
REQ-019 IDLE: start=1 -> capture k_len, clear err, go CLEAR next cycle.
REQ-020 CLEAR: arr_clr=1 for exactly one cycle; k_len=0 -> DONE, else LOAD.
REQ-021 LOAD: op_rd=1 while beats remain; op_rd SHALL deassert in the cycle after the k_len-th acceptance and never overrun k_len.
REQ-022 Beat counter SHALL increment only on acceptance; after k_len acceptances -> FLUSH.
REQ-023 Cycles with op_valid=0 in LOAD SHALL inject an all-zero bubble into every lane simultaneously, preserving w/a pairing.
REQ-024 Skew: column lane j and row lane i SHALL be delayed by j and i cycles respectively via per-lane shift registers; lane 0 registered once (1-cycle base latency).
REQ-025 arr_fire SHALL pulse exactly once per job, in the cycle the first accepted beat appears on lane 0 outputs.
REQ-026 FLUSH: feed zeros for ROWS+COLS-2 cycles so skewed data fully enters the array, then DRAIN.
REQ-027 DRAIN: last_valid=1 -> DONE; after TMO DRAIN cycles without last_valid, set err and go DONE.
REQ-028 DONE: done=1 one cycle, then IDLE.
REQ-029 Outside LOAD/FLUSH skew-register inputs SHALL be zero; arr_w/arr_a SHALL be zero in IDLE.
REQ-030 start while busy SHALL be ignored; k_len changes while busy SHALL have no effect.
REQ-031 Beat counter width KW; k_len = 2^KW-1 SHALL complete without wrap.

Reset
REQ-032 rst=1 at any clock edge SHALL force IDLE and zero all outputs (op_rd, arr_fire, arr_clr, busy, done, err, arr_w, arr_a), beat and timeout counters, and all skew registers, including mid-job.
REQ-033 The first start is accepted in the cycle after rst deasserts.

Structure
REQ-034 FSM state enum and default ROWS/COLS/INWIDTH SHALL live in shared package arr_pkg.
REQ-035 Per-lane delay SHALL be sub-module skew_line (parameters DEPTH, WIDTH, DEPTH=0 meaning single register), instantiated ROWS+COLS times.

Verification
REQ-036 k_len=4, op_valid constant 1 -> arr_clr at cycle 1, four op_rd acceptances, one arr_fire, lane 3 data arrives 3 cycles after lane 0, done after last_valid.
REQ-037 k_len=3, op_valid pattern 1,0,1,0,1 -> exactly 3 acceptances, zero bubbles at identical positions on all lanes, arr_fire once.
REQ-038 k_len=0 -> CLEAR then DONE, no op_rd, no arr_fire, done pulse at cycle 2.
REQ-039 last_valid tied 0, k_len=2 -> err=1 and done after 64 DRAIN cycles; next start clears err.
REQ-040 rst asserted mid-LOAD with k_len=8 -> next cycle IDLE, all outputs zero, following start runs full job.
REQ-041 start pulsed during DRAIN -> ignored, single done, FSM returns to IDLE.
